video_timing_gen: RTL

Parametrised successor to the System86 timing generator. Runs entirely on one master clock and derives a pixel clock-enable from it. Generates H/V counters, sync, blank and reset strobes, with programmable window positions including windows that wrap through zero. Adds a raster-line interrupt with an acknowledge handshake and a frame-parity output, for reuse across Namco board variants.

---
 rtl/video_timing_pkg.sv | 31 +++
 rtl/video_timing_gen_timing_axis.sv | 38 +++
 rtl/video_timing_gen.sv | 126 ++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - System86 timing defaults and window decode helper
package video_timing_pkg;

  localparam int DEF_CLK_DIV       = 8;
  localparam int DEF_H_W           = 9;
  localparam int DEF_V_W           = 9;
  localparam int DEF_H_TOTAL       = 384;
  localparam int DEF_V_TOTAL       = 264;
  localparam int DEF_H_BLANK_START = 272;
  localparam int DEF_H_BLANK_END   = 368;
  localparam int DEF_H_SYNC_START  = 304;
  localparam int DEF_H_SYNC_END    = 336;
  localparam int DEF_V_BLANK_START = 240;
  localparam int DEF_V_BLANK_END   = 16;
  localparam int DEF_V_SYNC_START  = 248;
  localparam int DEF_V_SYNC_END    = 0;
  localparam int DEF_H_RESET_POS   = 15;

  typedef logic [15:0] coord_t;

  // Half-open window [s,e); s>e wraps through zero, s==e is empty, e==0 runs to the end
  function automatic logic in_window(input coord_t c, input coord_t s, input coord_t e);
    if (s == e)
      return 1'b0;
    else if (s < e)
      return (c >= s) && (c < e);
    else
      return (c >= s) || (c < e);
  endfunction

endpackage

// File: rtl/video_timing_gen_timing_axis.sv
// rtl/video_timing_gen_timing_axis.sv - wrap counter with registered blank/sync decode
module timing_axis
  import video_timing_pkg::*;
#(
  parameter int W       = 9,
  parameter int TOTAL   = 384,
  parameter int BLANK_S = 272,
  parameter int BLANK_E = 368,
  parameter int SYNC_S  = 304,
  parameter int SYNC_E  = 336
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv,
  output logic [W-1:0] count,
  output logic [W-1:0] cnt_next,
  output logic         wrap,
  output logic         blank_n,
  output logic         sync_n
);

  assign wrap     = adv && (count == W'(TOTAL - 1));
  assign cnt_next = wrap ? '0 : (adv ? count + W'(1) : count);

  // Count and decode from the next value so the decode lines up with the registered count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      blank_n <= 1'b1;
      sync_n  <= 1'b1;
    end else begin
      count   <= cnt_next;
      blank_n <= ~in_window(16'(cnt_next), 16'(BLANK_S), 16'(BLANK_E));
      sync_n  <= ~in_window(16'(cnt_next), 16'(SYNC_S), 16'(SYNC_E));
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - pixel divider, H/V timing, raster IRQ and field parity
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CLK_DIV       = DEF_CLK_DIV,
  parameter int H_W           = DEF_H_W,
  parameter int V_W           = DEF_V_W,
  parameter int H_TOTAL       = DEF_H_TOTAL,
  parameter int V_TOTAL       = DEF_V_TOTAL,
  parameter int H_BLANK_START = DEF_H_BLANK_START,
  parameter int H_BLANK_END   = DEF_H_BLANK_END,
  parameter int H_SYNC_START  = DEF_H_SYNC_START,
  parameter int H_SYNC_END    = DEF_H_SYNC_END,
  parameter int V_BLANK_START = DEF_V_BLANK_START,
  parameter int V_BLANK_END   = DEF_V_BLANK_END,
  parameter int V_SYNC_START  = DEF_V_SYNC_START,
  parameter int V_SYNC_END    = DEF_V_SYNC_END,
  parameter int H_RESET_POS   = DEF_H_RESET_POS
) (
  input  logic           CLK_48M,
  input  logic           rst_n,
  input  logic           IRQ_EN,
  input  logic [V_W-1:0] IRQ_LINE,
  input  logic           IRQ_ACK,
  output logic           PIX_CE,
  output logic [H_W-1:0] H_COUNT,
  output logic [V_W-1:0] V_COUNT,
  output logic           nHSYNC,
  output logic           nVSYNC,
  output logic           nHBLANK,
  output logic           nVBLANK,
  output logic           nHRESET,
  output logic           nVRESET,
  output logic           CLK_1H,
  output logic           CLK_2H,
  output logic           CLK_4H,
  output logic           CLK_1V,
  output logic           CLK_4V,
  output logic           CLK_8V,
  output logic           FIELD,
  output logic           nIRQ
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0]  div;
  logic [DW-1:0]  div_next;
  logic [H_W-1:0] h_next;
  logic [V_W-1:0] v_next;
  logic           h_wrap;
  logic           v_wrap;
  logic           irq_set;

  assign div_next = (div == DW'(CLK_DIV - 1)) ? '0 : div + DW'(1);

  // Master-clock divider; PIX_CE is high exactly while the divider holds CLK_DIV-1
  always_ff @(posedge CLK_48M or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      PIX_CE <= 1'b0;
    end else begin
      div    <= div_next;
      PIX_CE <= (div_next == DW'(CLK_DIV - 1));
    end
  end

  timing_axis #(
    .W(H_W), .TOTAL(H_TOTAL),
    .BLANK_S(H_BLANK_START), .BLANK_E(H_BLANK_END),
    .SYNC_S(H_SYNC_START), .SYNC_E(H_SYNC_END)
  ) u_h_axis (
    .clk(CLK_48M), .rst_n(rst_n), .adv(PIX_CE),
    .count(H_COUNT), .cnt_next(h_next), .wrap(h_wrap),
    .blank_n(nHBLANK), .sync_n(nHSYNC)
  );

  timing_axis #(
    .W(V_W), .TOTAL(V_TOTAL),
    .BLANK_S(V_BLANK_START), .BLANK_E(V_BLANK_END),
    .SYNC_S(V_SYNC_START), .SYNC_E(V_SYNC_END)
  ) u_v_axis (
    .clk(CLK_48M), .rst_n(rst_n), .adv(h_wrap),
    .count(V_COUNT), .cnt_next(v_next), .wrap(v_wrap),
    .blank_n(nVBLANK), .sync_n(nVSYNC)
  );

  assign CLK_1H = H_COUNT[0];
  assign CLK_2H = H_COUNT[1];
  assign CLK_4H = H_COUNT[2];
  assign CLK_1V = V_COUNT[0];
  assign CLK_4V = V_COUNT[2];
  assign CLK_8V = V_COUNT[3];

  // Reset strobes, decoded from next counts so they align with H_COUNT/V_COUNT
  always_ff @(posedge CLK_48M or negedge rst_n) begin
    if (!rst_n) begin
      nHRESET <= 1'b1;
      nVRESET <= 1'b1;
    end else begin
      nHRESET <= ~(h_next == H_W'(H_RESET_POS));
      nVRESET <= ~((h_next == H_W'(H_RESET_POS)) && (v_next == '0));
    end
  end

  // Field parity flips once per frame on the vertical wrap
  always_ff @(posedge CLK_48M or negedge rst_n) begin
    if (!rst_n)
      FIELD <= 1'b0;
    else if (v_wrap)
      FIELD <= ~FIELD;
  end

  // Lines past V_TOTAL-1 never match v_next, so out-of-range IRQ_LINE cannot fire
  assign irq_set = h_wrap && IRQ_EN && (v_next == IRQ_LINE);

  // Raster IRQ latch; a set event beats a coincident acknowledge
  always_ff @(posedge CLK_48M or negedge rst_n) begin
    if (!rst_n)
      nIRQ <= 1'b1;
    else if (irq_set)
      nIRQ <= 1'b0;
    else if (IRQ_ACK)
      nIRQ <= 1'b1;
  end

endmodule
